// File: rtl/inference_sequencer.sv
// Inference run sequencer: streams each image from pixel memory into the
// pipeline, collects its class decision and scores it against the golden label.
module inference_sequencer #(
   parameter int PIX_BITS   = 8,
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28,
   parameter int NUM_IMG    = 1000,
   parameter int ADDR_BITS  = 20,
   parameter int CNT_BITS   = 10,
   parameter int CLASS_BITS = 4,
   parameter int RST_CYC    = 3,
   parameter int TIMEOUT    = 4096
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [ADDR_BITS-1:0]  pix_addr,
   input  logic [PIX_BITS-1:0]   pix_rdata,
   output logic [PIX_BITS-1:0]   data_out,
   output logic                  data_valid,
   output logic                  pipe_rst_n,
   input  logic [CLASS_BITS-1:0] decision_in,
   input  logic                  decision_valid,
   output logic [CNT_BITS-1:0]   img_idx,
   input  logic [CLASS_BITS-1:0] label_in,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err,
   output logic [CNT_BITS-1:0]   hit_cnt,
   output logic [CNT_BITS-1:0]   img_cnt
);

   localparam int IMG_PIX = IMG_W * IMG_H;
   localparam int PW = $clog2(IMG_PIX + 1);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int RW = $clog2(RST_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRST,
      S_STREAM,
      S_WAIT,
      S_DONE
   } state_t;

   state_t state, state_nx;

   logic [RW-1:0] rst_cnt;
   logic [PW-1:0] pix_idx;
   logic [WW-1:0] wait_cnt;

   logic go, adv, dec, tmo, more;
   logic pix_last, rst_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      go       = 1'b0;
      adv      = 1'b0;
      dec      = 1'b0;
      tmo      = 1'b0;
      more     = (img_cnt + CNT_BITS'(1)) < CNT_BITS'(NUM_IMG);
      pix_last = (pix_idx == PW'(IMG_PIX - 1));
      rst_last = (rst_cnt == RW'(RST_CYC - 1));
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               go       = 1'b1;
               state_nx = S_PRST;
            end
         end
         S_PRST: begin
            if (rst_last) state_nx = S_STREAM;
         end
         S_STREAM: begin
            if (pix_last) state_nx = S_WAIT;
         end
         S_WAIT: begin
            // the timeout clock only runs once the last pixel has left
            dec = decision_valid;
            tmo = !decision_valid && !data_valid
                  && (wait_cnt == WW'(TIMEOUT - 1));
            adv = dec || tmo;
            if (adv) state_nx = more ? S_PRST : S_DONE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_rst_n  <= 1'b0;
         data_valid  <= 1'b0;
         data_out    <= '0;
         pix_addr    <= '0;
         img_idx     <= '0;
         hit_cnt     <= '0;
         img_cnt     <= '0;
         timeout_err <= 1'b0;
         rst_cnt     <= '0;
         pix_idx     <= '0;
         wait_cnt    <= '0;
      end else begin
         pipe_rst_n <= (state_nx != S_PRST);
         data_valid <= (state == S_STREAM);
         if (state == S_STREAM) data_out <= pix_rdata;
         rst_cnt  <= (state == S_PRST) ? rst_cnt + RW'(1) : '0;
         pix_idx  <= (state == S_STREAM) ? pix_idx + PW'(1) : '0;
         wait_cnt <= (state == S_WAIT && !data_valid)
                     ? wait_cnt + WW'(1) : '0;
         if (go) begin
            hit_cnt     <= '0;
            img_cnt     <= '0;
            img_idx     <= '0;
            timeout_err <= 1'b0;
            pix_addr    <= '0;
         end
         if (state == S_STREAM && !pix_last)
            pix_addr <= pix_addr + ADDR_BITS'(1);
         if (adv) begin
            img_cnt <= img_cnt + CNT_BITS'(1);
            if (dec && decision_in == label_in)
               hit_cnt <= hit_cnt + CNT_BITS'(1);
            if (tmo) timeout_err <= 1'b1;
            if (more) begin
               img_idx  <= img_idx + CNT_BITS'(1);
               pix_addr <= pix_addr + ADDR_BITS'(1);
            end
         end
      end
   end

   assign busy = (state == S_PRST) || (state == S_STREAM)
                 || (state == S_WAIT);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer: nominal, timeout, same-cycle race,
// ignored inputs and mid-run reset on a 2x2, 3-image configuration.
module tb_inference_sequencer;

   localparam int PB = 8;
   localparam int AB = 8;
   localparam int CB = 4;
   localparam int KB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AB-1:0] pix_addr;
   logic [PB-1:0] pix_rdata;
   logic [PB-1:0] data_out;
   logic          data_valid;
   logic          pipe_rst_n;
   logic [KB-1:0] decision_in = '0;
   logic          decision_valid = 1'b0;
   logic [CB-1:0] img_idx;
   logic [KB-1:0] label_in;
   logic          busy, done, timeout_err;
   logic [CB-1:0] hit_cnt, img_cnt;

   int total = 0;
   int bad = 0;
   int total_pix = 0;
   int base;

   always #5 clk = ~clk;

   // pixel memory holds value = address
   assign pix_rdata = pix_addr;
   assign label_in = (img_idx == 4'd0) ? 4'd5 :
                     (img_idx == 4'd1) ? 4'd1 : 4'd2;

   inference_sequencer #(
      .PIX_BITS(PB), .IMG_W(2), .IMG_H(2), .NUM_IMG(3),
      .ADDR_BITS(AB), .CNT_BITS(CB), .CLASS_BITS(KB),
      .RST_CYC(2), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .pix_addr(pix_addr), .pix_rdata(pix_rdata),
      .data_out(data_out), .data_valid(data_valid),
      .pipe_rst_n(pipe_rst_n),
      .decision_in(decision_in), .decision_valid(decision_valid),
      .img_idx(img_idx), .label_in(label_in),
      .busy(busy), .done(done), .timeout_err(timeout_err),
      .hit_cnt(hit_cnt), .img_cnt(img_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // returns at the negedge of the first cycle after the last data_valid
   task automatic to_w1();
      int n = 0;
      bit seen = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (data_valid) seen = 1;
         else if (seen) break;
      end
      chk("wait_bound", 32'(n < 200), 1);
   endtask

   task automatic decide(input logic [KB-1:0] d);
      decision_in = d;
      decision_valid = 1'b1;
      @(negedge clk);
      decision_valid = 1'b0;
   endtask

   // stream monitor: address/data pairing, pixel order, burst lengths
   int dv_run = 0;
   int low_run = 0;
   int exp_pix = 0;
   logic [AB-1:0] last_addr = '0;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv_run = 0;
         low_run = 0;
         exp_pix = 0;
         last_addr = '0;
      end else begin
         if (data_valid) begin
            chk("data_vs_addr", 32'(data_out), 32'(last_addr));
            chk("pix_seq", 32'(data_out), exp_pix);
            exp_pix++;
            total_pix++;
            dv_run++;
         end else if (dv_run != 0) begin
            chk("dv_len", dv_run, 4);
            dv_run = 0;
         end
         if (busy && !pipe_rst_n) low_run++;
         else if (low_run != 0) begin
            chk("prst_len", low_run, 2);
            low_run = 0;
         end
         if (!busy) exp_pix = 0;
         last_addr = pix_addr;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int n;
      // reset state
      #1;
      chk("rst_pipe", 32'(pipe_rst_n), 0);
      chk("rst_dv", 32'(data_valid), 0);
      chk("rst_addr", 32'(pix_addr), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_hit", 32'(hit_cnt), 0);
      chk("rst_img", 32'(img_cnt), 0);
      chk("rst_tmo", 32'(timeout_err), 0);
      cyc(2);
      #2 rst_n = 1'b1;
      #1 chk("pipe_before_edge", 32'(pipe_rst_n), 0);
      cyc(1);
      chk("pipe_idle", 32'(pipe_rst_n), 1);

      // nominal: decisions 5,7,2 vs labels 5,1,2
      base = total_pix;
      pulse_start();
      chk("n_busy", 32'(busy), 1);
      chk("n_pipe_low", 32'(pipe_rst_n), 0);
      for (int i = 0; i < 3; i++) begin
         to_w1();
         chk("n_idx", 32'(img_idx), i);
         decide((i == 0) ? 4'd5 : (i == 1) ? 4'd7 : 4'd2);
         chk("n_imgcnt", 32'(img_cnt), i + 1);
      end
      chk("n_done", 32'(done), 1);
      chk("n_busy_end", 32'(busy), 0);
      chk("n_hit", 32'(hit_cnt), 2);
      chk("n_img", 32'(img_cnt), 3);
      chk("n_tmo", 32'(timeout_err), 0);
      chk("n_idx_hold", 32'(img_idx), 2);
      chk("n_pixels", total_pix - base, 12);

      // timeout on image 1
      base = total_pix;
      pulse_start();
      chk("t_done_clr", 32'(done), 0);
      chk("t_hit_clr", 32'(hit_cnt), 0);
      chk("t_img_clr", 32'(img_cnt), 0);
      chk("t_addr_clr", 32'(pix_addr), 0);
      to_w1();
      decide(4'd5);
      to_w1();
      cyc(7);
      chk("t_pre_tmo", 32'(timeout_err), 0);
      chk("t_pre_img", 32'(img_cnt), 1);
      cyc(1);
      chk("t_tmo", 32'(timeout_err), 1);
      chk("t_img", 32'(img_cnt), 2);
      chk("t_hit", 32'(hit_cnt), 1);
      chk("t_next_prst", 32'(pipe_rst_n), 0);
      chk("t_next_idx", 32'(img_idx), 2);
      to_w1();
      decide(4'd2);
      chk("t_hit_end", 32'(hit_cnt), 2);
      chk("t_img_end", 32'(img_cnt), 3);
      chk("t_tmo_end", 32'(timeout_err), 1);
      chk("t_done", 32'(done), 1);
      chk("t_pixels", total_pix - base, 12);

      // decision on the timeout cycle, then ignored start/decision
      pulse_start();
      chk("s_tmo_clr", 32'(timeout_err), 0);
      to_w1();
      decide(4'd5);
      to_w1();
      cyc(7);
      decide(4'd1);
      chk("s_tmo", 32'(timeout_err), 0);
      chk("s_hit", 32'(hit_cnt), 2);
      chk("s_img", 32'(img_cnt), 2);
      start = 1'b1;
      decision_in = 4'd2;
      decision_valid = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(3);
      decision_valid = 1'b0;
      chk("i_hit", 32'(hit_cnt), 2);
      chk("i_img", 32'(img_cnt), 2);
      chk("i_busy", 32'(busy), 1);
      chk("i_idx", 32'(img_idx), 2);
      to_w1();
      decide(4'd3);
      chk("s_hit_end", 32'(hit_cnt), 2);
      chk("s_img_end", 32'(img_cnt), 3);
      chk("s_done", 32'(done), 1);

      // reset during image 1 stream
      pulse_start();
      to_w1();
      decide(4'd5);
      n = 0;
      while (n < 100 && !(data_valid && img_idx == 4'd1)) begin
         @(negedge clk);
         n++;
      end
      chk("r_reach", 32'(n < 100), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("r_busy", 32'(busy), 0);
      chk("r_dv", 32'(data_valid), 0);
      chk("r_dout", 32'(data_out), 0);
      chk("r_addr", 32'(pix_addr), 0);
      chk("r_idx", 32'(img_idx), 0);
      chk("r_img", 32'(img_cnt), 0);
      chk("r_hit", 32'(hit_cnt), 0);
      chk("r_pipe", 32'(pipe_rst_n), 0);
      chk("r_done", 32'(done), 0);
      cyc(2);
      #2 rst_n = 1'b1;
      cyc(1);
      chk("r_idle_pipe", 32'(pipe_rst_n), 1);
      chk("r_idle_busy", 32'(busy), 0);
      base = total_pix;
      pulse_start();
      chk("r_addr0", 32'(pix_addr), 0);
      for (int i = 0; i < 3; i++) begin
         to_w1();
         decide((i == 0) ? 4'd5 : (i == 1) ? 4'd1 : 4'd2);
      end
      chk("r_hit_end", 32'(hit_cnt), 3);
      chk("r_img_end", 32'(img_cnt), 3);
      chk("r_done_end", 32'(done), 1);
      chk("r_pixels", total_pix - base, 12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inference_sequencer.md
INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 Parameter PIX_BITS, 8: pixel width.
REQ-002 Parameter IMG_W, 28 and IMG_H, 28: image width and height; IMG_PIX = IMG_W*IMG_H.
REQ-003 Parameter NUM_IMG, 1000: images per run, at least 1.
REQ-004 Parameter ADDR_BITS, 20: pixel memory address width, at least clog2(NUM_IMG*IMG_PIX).
REQ-005 Parameter CNT_BITS, 10: width of the image and hit counters, at least clog2(NUM_IMG+1).
REQ-006 Parameter CLASS_BITS, 4: decision and label width.
REQ-007 Parameter RST_CYC, 3: pipeline soft-reset length in cycles, at least 1.
REQ-008 Parameter TIMEOUT, 4096: maximum WAIT cycles per image.
REQ-009 clk  in  1  single clock; all logic is on its rising edge.
REQ-010 rst_n  in  1  asynchronous, active-low reset.
REQ-011 start  in  1  one-cycle pulse that begins a run.
REQ-012 pix_addr  out  ADDR_BITS  pixel memory read address.
REQ-013 pix_rdata  in  PIX_BITS  memory data, valid one cycle after its address.
REQ-014 data_out  out  PIX_BITS  pixel to the inference pipeline.
REQ-015 data_valid  out  1  data_out qualifier.
REQ-016 pipe_rst_n  out  1  active-low soft reset to the inference pipeline.
REQ-017 decision_in  in  CLASS_BITS  pipeline class result.
REQ-018 decision_valid  in  1  decision_in qualifier.
REQ-019 img_idx  out  CNT_BITS  index of the current image.
REQ-020 label_in  in  CLASS_BITS  golden label for img_idx, combinational.
REQ-021 busy, done, timeout_err  out  1 each  status flags.
REQ-022 hit_cnt, img_cnt  out  CNT_BITS each  correct decisions; images completed.

Function
REQ-023 FSM states: IDLE, PRST, STREAM, WAIT, DONE.
REQ-024 IDLE/DONE transitions: on start, clear hit_cnt, img_cnt, img_idx, timeout_err and done, then go to PRST; start in any other state is ignored.
REQ-025 PRST holds pipe_rst_n=0 for exactly RST_CYC cycles, then goes to STREAM; pipe_rst_n=1 in every other state.
REQ-026 STREAM issues pix_addr = img_idx*IMG_PIX + pix_idx for pix_idx 0..IMG_PIX-1, one address per cycle, no gaps.
REQ-027 Each data_out equals pix_rdata registered from an address issued one cycle earlier; data_valid is high for exactly IMG_PIX consecutive cycles per image.
REQ-028 After the last address, move to WAIT; the WAIT counter starts on the cycle after the last data_valid.
REQ-029 WAIT with decision_valid: hit_cnt increments if decision_in==label_in, img_cnt increments, and the FSM advances.
REQ-030 WAIT timeout: if TIMEOUT cycles pass with no decision_valid, set timeout_err (sticky), increment img_cnt only (counted as a miss), and advance.
REQ-031 If decision_valid and timeout occur in the same cycle, the decision wins.
REQ-032 decision_valid outside WAIT is ignored, with no counter change.
REQ-033 Advance: if img_cnt+1 < NUM_IMG, increment img_idx and go to PRST; otherwise go to DONE with done=1, holding img_idx at NUM_IMG-1.
REQ-034 busy=1 in PRST, STREAM and WAIT; busy=0 in IDLE and DONE.
REQ-035 Counters never wrap; hit_cnt <= img_cnt <= NUM_IMG always.

Reset
REQ-036 On rst_n low, immediately: state IDLE, pipe_rst_n=0, data_valid=0, data_out=0, pix_addr=0, img_idx=0, hit_cnt=0, img_cnt=0, busy=0, done=0, timeout_err=0.
REQ-037 After rst_n deasserts, pipe_rst_n=1 from the first clock edge in IDLE.
REQ-038 rst_n asserted mid-run aborts the run with no partial counts retained; a new start is required.

Verification (parameters IMG_W=2, IMG_H=2, NUM_IMG=3, RST_CYC=2, TIMEOUT=8)
REQ-039 Nominal run: start, then decisions 5,7,2 against labels 5,1,2 -> hit_cnt=2, img_cnt=3, done=1, timeout_err=0, and pix_addr sequence 0..11.
REQ-040 Streaming timing: pixel memory holds value=address -> data_out 0,1,2,3 on consecutive cycles, each one cycle after its address, with pipe_rst_n low exactly 2 cycles before each image.
REQ-041 Timeout: no decision for image 1 -> timeout_err=1 eight cycles after the last data_valid; final img_cnt=3 and hit_cnt counts only images 0 and 2.
REQ-042 Same-cycle decision and timeout: decision_valid on WAIT cycle 8 with a matching label -> counted as a hit, timeout_err=0.
REQ-043 Spurious and ignored inputs: decision_valid during STREAM, and start while busy -> no counter or state change.
REQ-044 Mid-run reset: rst_n low during image 1 STREAM -> all outputs at reset values asynchronously; a new start re-runs from pix_addr 0.
